// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stack
//  Description : LIFO operand stack with push, pop and replace operations.
//                Exposes the top and second-from-top words combinationally
//                as ALU operands. Sticky overflow/underflow error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           clr_err,
    output logic [WIDTH-1:0]               data_out,
    output logic [WIDTH-1:0]               next_out,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [1:0]       w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_next_idx;

    // Decode occupancy and read indices from the stack pointer. Modular AW-bit
    // arithmetic gives the right index even when sp == DEPTH (low bits are 0).
    always_comb begin
        w_empty    = (sp_q == '0);
        w_full     = (sp_q == CW'(DEPTH));
        w_top_idx  = sp_q[AW-1:0] - AW'(1);
        w_next_idx = sp_q[AW-1:0] - AW'(2);
        w_op       = en ? {push, pop} : OP_IDLE;
    end

    // Next-state: pointer movement, memory write request and sticky errors.
    // clr_err clears first so that an error on the same edge wins.
    always_comb begin
        sp_d        = sp_q;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        w_wr_en     = 1'b0;
        w_wr_idx    = sp_q[AW-1:0];
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    overflow_d = 1'b1;
                end else begin
                    w_wr_en = 1'b1;
                    sp_d    = sp_q + CW'(1);
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    sp_d = sp_q - CW'(1);
                end
            end
            OP_REPLACE: begin
                // An empty stack has nothing to replace, so this is a plain push.
                w_wr_en = 1'b1;
                if (w_empty) begin
                    sp_d = sp_q + CW'(1);
                end else begin
                    w_wr_idx = w_top_idx;
                end
            end
            default: begin
                sp_d = sp_q;
            end
        endcase
    end

    // Pointer and error flags; async active-low reset empties the stack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; no reset needed since entries above sp are never shown.
    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            mem_q[w_wr_idx] <= data_in;
        end
    end

    // Operand outputs read straight from registered state, masked when invalid.
    always_comb begin
        data_out  = w_empty ? '0 : mem_q[w_top_idx];
        next_out  = (sp_q >= CW'(2)) ? mem_q[w_next_idx] : '0;
        count     = sp_q;
        empty     = w_empty;
        full      = w_full;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_stack
//  Description : Self-checking directed bench for operand_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stack;

    logic       clk;
    logic       reset;
    logic       en;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       clr_err;
    logic [7:0] data_out;
    logic [7:0] next_out;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_chk;
    int n_pass;

    typedef struct {
        logic       e;
        logic       p;
        logic       o;
        logic       c;
        logic [7:0] din;
        logic [7:0] dout;
        logic [7:0] nout;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[14];

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .next_out  (next_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic p, input logic o, input logic c,
                                input logic [7:0] din, input logic [7:0] dout,
                                input logic [7:0] nout, input logic [4:0] cnt,
                                input logic emp, input logic ful,
                                input logic ovf, input logic unf);
        vec_t v;
        v.e = e; v.p = p; v.o = o; v.c = c; v.din = din;
        v.dout = dout; v.nout = nout; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] dout, input logic [7:0] nout,
                         input logic [4:0] cnt, input logic emp, input logic ful,
                         input logic ovf, input logic unf);
        logic [24:0] act;
        logic [24:0] exp;
        act = {data_out, next_out, count, empty, full, overflow, underflow};
        exp = {dout, nout, cnt, emp, ful, ovf, unf};
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got dout=%h nout=%h cnt=%0d emp=%b ful=%b ovf=%b unf=%b, want dout=%h nout=%h cnt=%0d emp=%b ful=%b ovf=%b unf=%b",
                     name, data_out, next_out, count, empty, full, overflow, underflow,
                     dout, nout, cnt, emp, ful, ovf, unf);
        end
    endtask

    // Drive one set of inputs for a single rising edge, then settle past it.
    task automatic step(input logic e, input logic p, input logic o, input logic c,
                        input logic [7:0] d);
        @(negedge clk);
        en = e; push = p; pop = o; clr_err = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;

        //            e     p     o     c     din    dout   nout   cnt   emp   ful   ovf   unf
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 8'h22, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h5A, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h78, 8'h5A, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h79, 8'h5A, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h33, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h44, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 8'h44, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        do_reset();
        #1;
        check("reset", 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Table: push/replace/en-gating/pop/underflow/clear/replace-on-empty/idle
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].c, tbl[i].din);
            check($sformatf("vec%0d", i), tbl[i].dout, tbl[i].nout, tbl[i].cnt,
                  tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].unf);
        end

        // Fill to full, overflow, clear, pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            check($sformatf("fill%0d", i), 8'(i), (i == 0) ? 8'h00 : 8'(i - 1),
                  5'(i + 1), 1'b0, (i == 15), 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        check("push_full", 8'h0F, 8'h0E, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("clr_ovf", 8'h0F, 8'h0E, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE);
        check("ovf_beats_clr", 8'h0F, 8'h0E, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hAB);
        check("replace_full", 8'hAB, 8'h0E, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("pop_after_full", 8'h0E, 8'h0D, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset between edges at count 5, then resume normally
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        end
        check("pre_async", 8'h34, 8'h33, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        en = 1'b1; push = 1'b1; pop = 1'b0; data_in = 8'hC3;
        @(posedge clk);
        #1;
        check("held_in_reset", 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", 8'hC3, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
